// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and optionally auto-repeat the
// clock-set push-buttons before they reach the clock core.
// Channel map: [0] hour, [1] min, [2] sec, [3] alarm, [4] alarm on/off toggle.
// Build option: define BTN_AUTOREPEAT_EN to add the per-channel hold/repeat FSM
// (REPEAT_MASK selects which channels repeat). Without it, every channel gives
// exactly one btn_pulse per debounced press and no repeat counters exist.
module button_conditioner #(
    parameter int               N_BTN               = 5,
    parameter int               DEBOUNCE_CYCLES     = 250000,
    parameter int               REPEAT_DELAY_CYCLES = 12500000,
    parameter int               REPEAT_RATE_CYCLES  = 2500000,
    parameter logic [N_BTN-1:0] REPEAT_MASK         = 5'b01111
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int RC_W    = $clog2(RPT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;
`endif

    logic [N_BTN-1:0] sync1_reg;
    logic [N_BTN-1:0] sync2_reg;

    // Two-stage synchroniser; the second stage feeds the debouncer directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_chan
            logic            level_reg;
            logic            level_next;
            logic [DB_W-1:0] db_cnt_reg;
            logic [DB_W-1:0] db_cnt_next;
            logic            flip;
            logic            rise;
            logic            fall;
            logic            pulse_reg;
            logic            pulse_next;

            // Debounce: count consecutive cycles that disagree with the accepted
            // level; any agreeing cycle restarts the count.
            always_comb begin
                flip        = 1'b0;
                db_cnt_next = db_cnt_reg;
                if (sync2_reg[gi] == level_reg) begin
                    db_cnt_next = '0;
                end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    flip        = 1'b1;
                    db_cnt_next = '0;
                end else begin
                    db_cnt_next = db_cnt_reg + 1'b1;
                end
                level_next = level_reg ^ flip;
            end

            assign rise = flip & ~level_reg;
            assign fall = flip &  level_reg;

            // Accepted level, debounce counter and the registered pulse output.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    level_reg  <= 1'b0;
                    db_cnt_reg <= '0;
                    pulse_reg  <= 1'b0;
                end else begin
                    level_reg  <= level_next;
                    db_cnt_reg <= db_cnt_next;
                    pulse_reg  <= pulse_next;
                end
            end

`ifdef BTN_AUTOREPEAT_EN
            rpt_state_t      state_reg;
            rpt_state_t      state_next;
            logic [RC_W-1:0] rcnt_reg;
            logic [RC_W-1:0] rcnt_next;

            // Hold/repeat FSM: press pulse on the debounced rise, first repeat
            // after the delay, then at the repeat rate; release wins over a due
            // repeat so no pulse is emitted on the release cycle.
            always_comb begin
                state_next = state_reg;
                rcnt_next  = rcnt_reg;
                pulse_next = 1'b0;
                case (state_reg)
                    ST_IDLE: begin
                        if (rise) begin
                            state_next = ST_HELD;
                            rcnt_next  = '0;
                            pulse_next = 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (fall) begin
                            state_next = ST_IDLE;
                            rcnt_next  = '0;
                        end else if (REPEAT_MASK[gi]) begin
                            if (rcnt_reg == RC_W'(REPEAT_DELAY_CYCLES - 1)) begin
                                state_next = ST_REPEAT;
                                rcnt_next  = '0;
                                pulse_next = 1'b1;
                            end else begin
                                rcnt_next = rcnt_reg + 1'b1;
                            end
                        end
                    end
                    ST_REPEAT: begin
                        if (fall) begin
                            state_next = ST_IDLE;
                            rcnt_next  = '0;
                        end else if (rcnt_reg == RC_W'(REPEAT_RATE_CYCLES - 1)) begin
                            rcnt_next  = '0;
                            pulse_next = 1'b1;
                        end else begin
                            rcnt_next = rcnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                        rcnt_next  = '0;
                    end
                endcase
            end

            // Repeat FSM state and hold-time counter.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_reg <= ST_IDLE;
                    rcnt_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    rcnt_reg  <= rcnt_next;
                end
            end
`else
            // Without auto-repeat a press yields exactly one pulse.
            always_comb begin
                pulse_next = rise;
            end
`endif

            assign btn_level[gi] = level_reg;
            assign btn_pulse[gi] = pulse_reg;
        end
    endgenerate

endmodule
